freq_code_detector: RTL and testbench

FREQ_CODE_DETECTOR -- requirements
Module: freq_code_detector

---
 rtl/freq_code_detector_pkg.sv | 47 ++++
 rtl/freq_code_detector_sync_edge_det.sv | 32 +++
 rtl/freq_code_detector.sv | 109 ++++++++++
 tb/tb_freq_code_detector.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/freq_code_detector_pkg.sv
// Shared constants and types for the frequency-code detector.
// The count table and tolerance are also consumed by the code-to-count translator.
package freq_code_detector_pkg;

    localparam int unsigned CntWidth  = 7;
    localparam int unsigned MeasWidth = CntWidth + 1;  // room for cnt + same-cycle tick
    localparam int unsigned NumCodes  = 8;

    localparam logic [CntWidth-1:0]  TimeoutCnt = 7'd127;
    localparam logic [MeasWidth-1:0] Tolerance  = 8'd1;

    // Half-period tick counts for codes 0..7 (30k .. 200k)
    localparam logic [MeasWidth-1:0] CodeCounts [NumCodes] = '{
        8'd104, 8'd62, 8'd41, 8'd31, 8'd25, 8'd21, 8'd18, 8'd15
    };

    typedef enum logic [0:0] {
        StIdle    = 1'b0,
        StMeasure = 1'b1
    } state_e;

    typedef struct packed {
        logic       hit;
        logic [2:0] code;
    } match_t;

    // Nominal half-period count for a code
    function automatic logic [MeasWidth-1:0] code_to_count(input logic [2:0] code);
        return CodeCounts[code];
    endfunction

    // Windows are disjoint, so at most one entry can hit
    function automatic match_t lookup_code(input logic [MeasWidth-1:0] meas);
        match_t                 res;
        logic [MeasWidth-1:0]   diff;
        res = '{hit: 1'b0, code: 3'd0};
        for (int unsigned k = 0; k < NumCodes; k++) begin
            diff = (meas >= CodeCounts[k]) ? (meas - CodeCounts[k]) : (CodeCounts[k] - meas);
            if (diff <= Tolerance) begin
                res.hit  = 1'b1;
                res.code = k[2:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/freq_code_detector_sync_edge_det.sv
// Two-flop synchronizer followed by a registered any-edge detector.
// Output pulse appears three clocks after the input changes.
module sync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic i_sig_in,
    output logic o_edge
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;
    logic r_edge;

    // Synchronize, keep previous level, register the level-change pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
            r_edge  <= 1'b0;
        end else begin
            r_sync1 <= i_sig_in;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_edge  <= r_sync2 ^ r_prev;
        end
    end

    assign o_edge = r_edge;

endmodule

// File: rtl/freq_code_detector.sv
// Measures half-periods of sig_in in ticks and classifies them into one of
// eight frequency codes; reports lock after two equal consecutive matches.
module freq_code_detector
    import freq_code_detector_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       sig_in,
    output logic [2:0] code,
    output logic       code_valid,
    output logic       locked,
    output logic       err
);

    logic                  w_edge;
    logic [MeasWidth-1:0]  w_meas_next;
    match_t                w_match;

    state_e                r_state;
    logic [CntWidth-1:0]   r_cnt;
    logic [MeasWidth-1:0]  r_meas;
    logic                  r_meas_vld;
    logic                  r_prev_vld;
    logic [2:0]            r_prev_code;
    logic [2:0]            r_code;
    logic                  r_code_valid;
    logic                  r_locked;
    logic                  r_err;

    sync_edge_det u_sync_edge_det (
        .clk      (clk),
        .rst      (rst),
        .i_sig_in (sig_in),
        .o_edge   (w_edge)
    );

    // A tick coinciding with the edge still belongs to the closing interval
    assign w_meas_next = {1'b0, r_cnt} + {{CntWidth{1'b0}}, tick};
    assign w_match     = lookup_code(r_meas);

    // Measurement FSM, capture register and registered match evaluation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= StIdle;
            r_cnt        <= '0;
            r_meas       <= '0;
            r_meas_vld   <= 1'b0;
            r_prev_vld   <= 1'b0;
            r_prev_code  <= 3'd0;
            r_code       <= 3'd0;
            r_code_valid <= 1'b0;
            r_locked     <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_meas_vld   <= 1'b0;
            r_code_valid <= 1'b0;

            case (r_state)
                StIdle: begin
                    r_cnt <= '0;
                    if (w_edge) begin
                        r_state    <= StMeasure;
                        r_prev_vld <= 1'b0;
                    end
                end
                StMeasure: begin
                    if (w_edge) begin
                        r_meas     <= w_meas_next;
                        r_meas_vld <= 1'b1;
                        r_cnt      <= '0;
                    end else if (r_cnt == TimeoutCnt) begin
                        // Signal stalled: abandon the interval
                        r_state    <= StIdle;
                        r_cnt      <= '0;
                        r_err      <= 1'b1;
                        r_locked   <= 1'b0;
                        r_prev_vld <= 1'b0;
                    end else if (tick) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= StIdle;
            endcase

            // Evaluation never coincides with a timeout: cnt was just cleared
            if (r_meas_vld) begin
                if (w_match.hit) begin
                    r_code       <= w_match.code;
                    r_code_valid <= 1'b1;
                    r_err        <= 1'b0;
                    r_locked     <= r_prev_vld && (r_prev_code == w_match.code);
                    r_prev_code  <= w_match.code;
                    r_prev_vld   <= 1'b1;
                end else begin
                    r_err      <= 1'b1;
                    r_locked   <= 1'b0;
                    r_prev_vld <= 1'b0;
                end
            end
        end
    end

    assign code       = r_code;
    assign code_valid = r_code_valid;
    assign locked     = r_locked;
    assign err        = r_err;

endmodule

// File: tb/tb_freq_code_detector.sv
// Self-checking bench for freq_code_detector: table of half-period vectors
// plus hand-written reset, lock-switch and zero-tick sequences.
module tb_freq_code_detector;

    logic       clk;
    logic       rst;
    logic       tick;
    logic       sig_in;
    logic [2:0] code;
    logic       code_valid;
    logic       locked;
    logic       err;

    typedef struct {
        int         period;
        int         n_tog;
        logic       hit;
        logic [2:0] code;
        logic       exp_err;
        logic       exp_locked;
    } vec_t;

    typedef struct {
        logic [2:0] code;
        logic       locked;
    } exp_t;

    exp_t exp_q[$];
    vec_t vecs[10];
    int   n_checks;
    int   n_errors;
    int   n_valid;

    freq_code_detector u_dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .sig_in     (sig_in),
        .code       (code),
        .code_valid (code_valid),
        .locked     (locked),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_exp(input logic [2:0] c, input logic l);
        exp_t e;
        e.code   = c;
        e.locked = l;
        exp_q.push_back(e);
    endtask

    task automatic check_outs_zero(input string tag);
        check({tag, " code"}, {29'd0, code}, 32'd0);
        check({tag, " code_valid"}, {31'd0, code_valid}, 32'd0);
        check({tag, " locked"}, {31'd0, locked}, 32'd0);
        check({tag, " err"}, {31'd0, err}, 32'd0);
    endtask

    // Scoreboard: every code_valid pulse must match the oldest expected result
    always @(negedge clk) begin
        if (!rst && code_valid) begin
            exp_t e;
            n_valid++;
            if (exp_q.size() == 0) begin
                check("unexpected code_valid", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("sb code", {29'd0, code}, {29'd0, e.code});
                check("sb locked", {31'd0, locked}, {31'd0, e.locked});
                check("sb err", {31'd0, err}, 32'd0);
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not complete (got timeout, expected finish)");
        $fatal(1);
    end

    initial begin
        int v0;
        n_checks = 0;
        n_errors = 0;
        n_valid  = 0;

        // period, toggles, hit, code, final err, final locked
        vecs[0] = '{31,  4, 1'b1, 3'd3, 1'b0, 1'b1};
        vecs[1] = '{105, 3, 1'b1, 3'd0, 1'b0, 1'b1};
        vecs[2] = '{108, 3, 1'b0, 3'd0, 1'b1, 1'b0};
        vecs[3] = '{61,  3, 1'b1, 3'd1, 1'b0, 1'b1};
        vecs[4] = '{16,  3, 1'b1, 3'd7, 1'b0, 1'b1};
        vecs[5] = '{20,  3, 1'b1, 3'd5, 1'b0, 1'b1};
        vecs[6] = '{23,  3, 1'b0, 3'd0, 1'b1, 1'b0};
        vecs[7] = '{126, 3, 1'b0, 3'd0, 1'b1, 1'b0};
        vecs[8] = '{42,  3, 1'b1, 3'd2, 1'b0, 1'b1};
        vecs[9] = '{19,  2, 1'b1, 3'd6, 1'b0, 1'b0};

        // Reset with sig_in toggling
        rst    = 1'b1;
        tick   = 1'b1;
        sig_in = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wait_cyc(3);
            sig_in = ~sig_in;
        end
        wait_cyc(2);
        check_outs_zero("in reset");
        rst = 1'b0;
        wait_cyc(5);
        check_outs_zero("after reset");

        // One edge only: starts a measurement, must not report
        sig_in = 1'b1;
        wait_cyc(40);
        check("single edge no valid", n_valid, 32'd0);
        wait_cyc(140);
        check("timeout err", {31'd0, err}, 32'd1);
        check("timeout locked", {31'd0, locked}, 32'd0);
        check("timeout no valid", n_valid, 32'd0);

        // Table-driven half-period vectors, each starting from idle
        foreach (vecs[vi]) begin
            for (int i = 0; i < vecs[vi].n_tog; i++) begin
                sig_in = ~sig_in;
                if (i > 0 && vecs[vi].hit)
                    push_exp(vecs[vi].code, (i >= 2));
                wait_cyc((i == vecs[vi].n_tog - 1) ? 8 : vecs[vi].period);
            end
            check($sformatf("vec%0d err", vi), {31'd0, err}, {31'd0, vecs[vi].exp_err});
            check($sformatf("vec%0d locked", vi), {31'd0, locked}, {31'd0, vecs[vi].exp_locked});
            wait_cyc(140);
            check($sformatf("vec%0d timeout err", vi), {31'd0, err}, 32'd1);
            check($sformatf("vec%0d timeout locked", vi), {31'd0, locked}, 32'd0);
        end

        // Locked at 31, then switch to 62
        sig_in = ~sig_in;
        wait_cyc(31);
        sig_in = ~sig_in; push_exp(3'd3, 1'b0);
        wait_cyc(31);
        sig_in = ~sig_in; push_exp(3'd3, 1'b1);
        wait_cyc(8);
        check("sw locked at 31", {31'd0, locked}, 32'd1);
        wait_cyc(54);
        sig_in = ~sig_in; push_exp(3'd1, 1'b0);
        wait_cyc(8);
        check("sw locked drop", {31'd0, locked}, 32'd0);
        check("sw code 1", {29'd0, code}, 32'd1);
        wait_cyc(54);
        sig_in = ~sig_in; push_exp(3'd1, 1'b1);
        wait_cyc(8);
        check("sw relock", {31'd0, locked}, 32'd1);
        wait_cyc(140);

        // Back-to-back edges with no ticks between them
        sig_in = ~sig_in;
        wait_cyc(31);
        sig_in = ~sig_in; push_exp(3'd3, 1'b0);
        wait_cyc(4);
        tick = 1'b0;
        wait_cyc(5);
        sig_in = ~sig_in;
        wait_cyc(8);
        check("zero-tick err", {31'd0, err}, 32'd1);
        check("zero-tick locked", {31'd0, locked}, 32'd0);
        check("zero-tick code holds", {29'd0, code}, 32'd3);
        tick = 1'b1;
        wait_cyc(140);

        // Reset in the middle of a 104-tick interval (sig_in low while measuring)
        if (sig_in) begin
            sig_in = 1'b0;
            wait_cyc(140);
        end
        sig_in = 1'b1;
        wait_cyc(31);
        sig_in = 1'b0; push_exp(3'd3, 1'b0);
        wait_cyc(53);
        check("pre-reset code", {29'd0, code}, 32'd3);
        rst = 1'b1;
        #1;
        check_outs_zero("mid reset");
        wait_cyc(3);
        rst = 1'b0;
        v0 = n_valid;
        wait_cyc(20);
        check("post-reset no valid", n_valid, v0);
        sig_in = 1'b1;
        wait_cyc(104);
        sig_in = 1'b0; push_exp(3'd0, 1'b0);
        wait_cyc(8);
        check("restart code 0", {29'd0, code}, 32'd0);
        check("restart err", {31'd0, err}, 32'd0);
        check("restart valid count", n_valid, v0 + 1);

        check("scoreboard drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
